multi_port_ram: RTL and testbench
=================================

# multi_port_ram

Parametrised synchronous RAM with one write port, `NUM_READ` independent registered read ports, per-byte write strobes, and a hardware clear sequencer that zeroes every entry after reset. It is the general-purpose storage macro for the core: the register file (two read ports), CSR shadow storage, and small buffers. Clearing is done in hardware, so contents are deterministic in both simulation and synthesis.

## Interface
- `DATA_WIDTH`, 32: word width in bits; must be a multiple of 8.
- `ADDR_WIDTH`, 5: address width; depth `DEPTH = 2**ADDR_WIDTH`.
- `NUM_READ`, 2: number of read ports, 1..4.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `we` input `DATA_WIDTH/8`: byte write strobes; bit b writes `dataIn[8b+7:8b]`.
- `wAddr` input `ADDR_WIDTH`: write address.
- `dataIn` input `DATA_WIDTH`: write data.
- `ren` input `NUM_READ`: per-port read enable.
- `rAddr` input `NUM_READ*ADDR_WIDTH`: port p address at `[p*ADDR_WIDTH +: ADDR_WIDTH]`.
- `q` output `NUM_READ*DATA_WIDTH`: port p data at `[p*DATA_WIDTH +: DATA_WIDTH]`, registered.
- `busy` output 1: high while the clear sequencer runs; the RAM ignores user traffic while high.

## Operation
- Two states: `CLEAR` and `READY`. A clock edge with `rst` high forces `CLEAR`, clear index `clrIdx <= 0`, all `q <= 0`, and `busy` high. Writes and reads in that cycle are ignored.
- In `CLEAR`, each edge with `rst` low:
  - writes `ram[clrIdx] <= 0` and increments `clrIdx`;
  - when `clrIdx == DEPTH-1`, moves to `READY`.
  - `we`, `ren` and the addresses are ignored, and `q` holds 0.
- In `READY`, `busy` is 0.
  - **Write:** on each edge, every byte b with `we[b]=1` updates that byte of `ram[wAddr]`. Bytes with `we[b]=0` keep their value. `we == 0` is no write.
  - **Read:** for each port p with `ren[p]=1`, `q_p <= ram[rAddr_p]`. With `ren[p]=0`, `q_p` holds its last value.
  - Ports are fully independent. Any number of ports may use the same address.
- Read-during-write to the same address: behaviour is set by the configuration macro (see Configuration).
- `rst` asserted during `CLEAR` or `READY` restarts clearing at index 0. Contents already cleared stay 0. Contents written before the reset are lost once clearing completes.
- Index and address arithmetic is unsigned with width `ADDR_WIDTH`. `clrIdx` never wraps, because the state leaves `CLEAR` at `DEPTH-1`.

## Timing
- **Reset values:** `q = 0` on all ports; `busy = 1`.
- **Clear duration:** `busy` falls exactly `DEPTH` edges after the first edge with `rst` low. With `ADDR_WIDTH=5`, that is 32 cycles.
- **Ready input:** the first input sampled is on the edge where `busy` is already 0.
- **Read latency:** 1 cycle. The address is sampled at edge N and `q` is valid after edge N.
- **Write latency:** a write at edge N is visible to a read sampled at edge N+1. This holds in both configurations.
- **No handshake beyond `busy`:** the user must not issue traffic while `busy` is high. Such traffic is discarded with no error indication.

## Configuration
- Macro: `MULTI_PORT_RAM_BYPASS_EN`.
- **Defined:** write-first. If port p reads address A on the same edge that A is written, `q_p` returns the new word, merged per byte. Written bytes come from `dataIn` and unwritten bytes from the old contents. Each read port has a compare-and-mux forwarding path for this.
- **Undefined:** read-first. `q_p` returns the old contents of A. There is no forwarding logic.

## Test plan
- **Reset and clear:** pre-write `0xDEADBEEF` to address 7, then pulse `rst` for 1 cycle. Expected: `busy` high for exactly 32 cycles, `q = 0` throughout, and reading address 7 afterwards returns `0x00000000`.
- **Byte strobes:** write `0x11223344` to address 3 with `we=4'b1111`, then `0xAABBCCDD` with `we=4'b0101`. Reading address 3 returns `0x11BB33DD` one cycle after `ren`.
- **Independent ports, read enable:** write address 1 = `0x1`, address 2 = `0x2`. Port 0 reads address 1 and port 1 reads address 2 on the same edge, giving `0x1` and `0x2`. Then drop `ren[1]` and change `rAddr1` to 1; port 1 still shows `0x2`.
- **Read-during-write:** address 5 holds `0x5`. Write `0x55` to address 5 while port 0 reads address 5 on the same edge. Expected `q0 = 0x55` with the macro defined and `0x5` without it. In both cases the next-cycle read gives `0x55`.
- **Traffic while busy:** write `0xFFFFFFFF` to address 0 during `CLEAR`. Expected: no effect, and address 0 reads `0` after `busy` falls.
- **Mid-clear reset:** assert `rst` at clear cycle 10. Expected: `busy` stays high for 32 further cycles after `rst` drops, and all entries read 0.

Source files
------------

// File: rtl/multi_port_ram.sv
// multi_port_ram: byte-strobed RAM with NUM_READ registered read ports and hardware clear; MULTI_PORT_RAM_BYPASS_EN selects write-first
module multi_port_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DATA_WIDTH/8-1:0]        we,
    input  logic [ADDR_WIDTH-1:0]          wAddr,
    input  logic [DATA_WIDTH-1:0]          dataIn,
    input  logic [NUM_READ-1:0]            ren,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] rAddr,
    output logic [NUM_READ*DATA_WIDTH-1:0] q,
    output logic                           busy
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int NB = DATA_WIDTH / 8;
    typedef enum logic {CLEAR, READY} state_t;
    state_t state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_idx_q, clr_idx_d;
    logic [NUM_READ*DATA_WIDTH-1:0] q_q, q_d;
    logic [DATA_WIDTH-1:0] ram [DEPTH];
    logic [NB-1:0] wr_be;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [ADDR_WIDTH-1:0] ra;
    logic [DATA_WIDTH-1:0] rd;
    always_comb begin
        state_d = (state_q == CLEAR && &clr_idx_q) ? READY : state_q;
        clr_idx_d = (state_q == CLEAR && !(&clr_idx_q)) ? clr_idx_q + 1'b1 : '0;
        wr_be = rst ? '0 : state_q == CLEAR ? '1 : we;
        wr_addr = state_q == CLEAR ? clr_idx_q : wAddr;
        wr_data = state_q == CLEAR ? '0 : dataIn;
        q_d = q_q;
        ra = '0;
        rd = '0;
        for (int p = 0; p < NUM_READ; p++) begin
            ra = rAddr[p*ADDR_WIDTH +: ADDR_WIDTH];
            rd = ram[ra];
`ifdef MULTI_PORT_RAM_BYPASS_EN
            for (int b = 0; b < NB; b++)
                if (we[b] && wAddr == ra) rd[8*b +: 8] = dataIn[8*b +: 8];
`endif
            if (state_q == CLEAR) q_d[p*DATA_WIDTH +: DATA_WIDTH] = '0;
            else if (ren[p]) q_d[p*DATA_WIDTH +: DATA_WIDTH] = rd;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            clr_idx_q <= '0;
            q_q <= '0;
        end else begin
            state_q <= state_d;
            clr_idx_q <= clr_idx_d;
            q_q <= q_d;
        end
    end
    always_ff @(posedge clk)
        for (int b = 0; b < NB; b++)
            if (wr_be[b]) ram[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
    assign q = q_q;
    assign busy = state_q == CLEAR;
endmodule

// File: tb/tb_multi_port_ram.sv
// tb_multi_port_ram: directed test with a cycle-level reference model of multi_port_ram
module tb_multi_port_ram;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int DEPTH = 32;
    logic clk = 0;
    logic rst;
    logic [3:0] we;
    logic [AW-1:0] wAddr;
    logic [DW-1:0] dataIn;
    logic [NR-1:0] ren;
    logic [NR*AW-1:0] rAddr;
    logic [NR*DW-1:0] q;
    logic busy;
    int total = 0;
    int bad = 0;
    bit running = 1;
    logic [DW-1:0] m_mem [DEPTH];
    logic [DW-1:0] m_q [NR];
    logic m_busy;
    int m_cnt;

    multi_port_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR)) dut (
        .clk(clk), .rst(rst), .we(we), .wAddr(wAddr), .dataIn(dataIn),
        .ren(ren), .rAddr(rAddr), .q(q), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    // reference model: clearing takes DEPTH unreset edges, after which the whole array is zero
    initial begin
        logic [DW-1:0] v;
        logic [AW-1:0] a;
        m_busy = 1;
        m_cnt = 0;
        for (int p = 0; p < NR; p++) m_q[p] = '0;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_busy = 1;
                m_cnt = 0;
                for (int p = 0; p < NR; p++) m_q[p] = '0;
            end else if (m_busy) begin
                m_cnt++;
                if (m_cnt == DEPTH) begin
                    m_busy = 0;
                    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
                end
            end else begin
                for (int p = 0; p < NR; p++)
                    if (ren[p]) begin
                        a = rAddr[p*AW +: AW];
                        v = m_mem[a];
`ifdef MULTI_PORT_RAM_BYPASS_EN
                        if (a == wAddr)
                            for (int b = 0; b < 4; b++) if (we[b]) v[8*b +: 8] = dataIn[8*b +: 8];
`endif
                        m_q[p] = v;
                    end
                for (int b = 0; b < 4; b++)
                    if (we[b]) m_mem[wAddr][8*b +: 8] = dataIn[8*b +: 8];
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (running) begin
                check("model_busy", {31'd0, busy}, {31'd0, m_busy});
                for (int p = 0; p < NR; p++) check("model_q", q[p*DW +: DW], m_q[p]);
            end
        end
    end

    task automatic wait_clear(string nm);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 100);
        check(nm, n, 32);
    endtask

    task automatic wr(logic [AW-1:0] a, logic [DW-1:0] d, logic [3:0] be);
        we = be;
        wAddr = a;
        dataIn = d;
        @(negedge clk);
        we = '0;
    endtask

    task automatic rd2(logic [AW-1:0] a0, logic [AW-1:0] a1);
        ren = 2'b11;
        rAddr = {a1, a0};
        @(negedge clk);
        ren = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1;
        we = '0;
        wAddr = '0;
        dataIn = '0;
        ren = '0;
        rAddr = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd1);
        check("reset_q0", q[31:0], 32'd0);
        check("reset_q1", q[63:32], 32'd0);
        rst = 0;
        wait_clear("init_clear_len");
        // reset and clear
        wr(7, 32'hDEADBEEF, 4'hF);
        rd2(7, 7);
        check("prewrite7", q[31:0], 32'hDEADBEEF);
        rst = 1;
        @(negedge clk);
        rst = 0;
        wait_clear("rst_clear_len");
        rd2(7, 7);
        check("cleared7", q[31:0], 32'd0);
        // byte strobes
        wr(3, 32'h11223344, 4'hF);
        wr(3, 32'hAABBCCDD, 4'b0101);
        rd2(3, 3);
        check("byte_strobe", q[31:0], 32'h11BB33DD);
        // independent ports and read enable
        wr(1, 32'h1, 4'hF);
        wr(2, 32'h2, 4'hF);
        rd2(1, 2);
        check("port0", q[31:0], 32'h1);
        check("port1", q[63:32], 32'h2);
        ren = 2'b01;
        rAddr = {5'd1, 5'd1};
        @(negedge clk);
        ren = '0;
        check("port1_hold", q[63:32], 32'h2);
        check("port0_same", q[31:0], 32'h1);
        // read during write
        wr(5, 32'h5, 4'hF);
        ren = 2'b01;
        rAddr = {5'd0, 5'd5};
        we = 4'hF;
        wAddr = 5;
        dataIn = 32'h55;
        @(negedge clk);
        we = '0;
        ren = '0;
`ifdef MULTI_PORT_RAM_BYPASS_EN
        check("rdw", q[31:0], 32'h55);
`else
        check("rdw", q[31:0], 32'h5);
`endif
        rd2(5, 5);
        check("rdw_next", q[31:0], 32'h55);
        // partial-strobe read during write on both ports
        ren = 2'b11;
        rAddr = {5'd5, 5'd5};
        we = 4'b0010;
        wAddr = 5;
        dataIn = 32'hA5A5A5A5;
        @(negedge clk);
        we = '0;
        ren = '0;
`ifdef MULTI_PORT_RAM_BYPASS_EN
        check("rdw_part", q[63:32], 32'h0000A555);
`else
        check("rdw_part", q[63:32], 32'h55);
`endif
        // traffic while busy
        wr(0, 32'h0BADF00D, 4'hF);
        rst = 1;
        @(negedge clk);
        rst = 0;
        we = 4'hF;
        wAddr = 0;
        dataIn = 32'hFFFFFFFF;
        ren = 2'b11;
        rAddr = '0;
        wait_clear("busy_traffic_len");
        we = '0;
        ren = '0;
        rd2(0, 0);
        check("busy_write_ignored", q[31:0], 32'd0);
        // mid-clear reset
        wr(9, 32'h12345678, 4'hF);
        wr(31, 32'hCAFEF00D, 4'hF);
        rst = 1;
        @(negedge clk);
        rst = 0;
        repeat (10) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        wait_clear("midclr_len");
        for (int i = 0; i < DEPTH; i++) begin
            rd2(AW'(i), AW'(DEPTH - 1 - i));
            check("midclr_zero0", q[31:0], 32'd0);
            check("midclr_zero1", q[63:32], 32'd0);
        end
        // a few more model-checked patterns
        for (int i = 0; i < 6; i++) wr(AW'(i + 20), 32'h01010101 * (i + 1), 4'hF);
        for (int i = 0; i < 6; i++) rd2(AW'(i + 20), AW'(25 - i));
        check("pattern_last0", q[31:0], 32'h06060606);
        check("pattern_last1", q[63:32], 32'h01010101);
        @(negedge clk);
        running = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
